// File: rtl/byteswap_job_scheduler_if.sv
// Requester, pipeline-control and completion signals of byteswap_job_scheduler.
// The scheduler connects through the slave modport; the environment uses master.
interface byteswap_job_scheduler_if #(
    parameter int C_NUM_REQ         = 4,
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int LP_ID_WIDTH       = $clog2(C_NUM_REQ)
);
    logic [C_NUM_REQ-1:0]                   req_valid;
    logic [C_NUM_REQ-1:0]                   req_ready;
    logic [C_NUM_REQ*C_ADDR_WIDTH-1:0]      req_addr;
    logic [C_NUM_REQ*C_XFER_SIZE_WIDTH-1:0] req_bytes;

    logic                         ctrl_start;
    logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset;
    logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_bytes;
    logic                         rd_done;
    logic                         wr_done;

    logic                   cpl_valid;
    logic                   cpl_ready;
    logic [LP_ID_WIDTH-1:0] cpl_id;
    logic                   cpl_status;

    modport slave (
        input  req_valid, req_addr, req_bytes, rd_done, wr_done, cpl_ready,
        output req_ready, ctrl_start, ctrl_addr_offset, ctrl_xfer_bytes,
               cpl_valid, cpl_id, cpl_status
    );

    modport master (
        output req_valid, req_addr, req_bytes, rd_done, wr_done, cpl_ready,
        input  req_ready, ctrl_start, ctrl_addr_offset, ctrl_xfer_bytes,
               cpl_valid, cpl_id, cpl_status
    );
endinterface

// File: rtl/byteswap_job_scheduler.sv
// Round-robin scheduler sharing one byteswap read/swap/write pipeline among requesters.
// Optional watchdog on the WAIT state: define BYTESWAP_SCHED_TIMEOUT_EN.
module byteswap_job_scheduler #(
    parameter int C_NUM_REQ         = 4,
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES  = 2**20,
    parameter int LP_ID_WIDTH       = $clog2(C_NUM_REQ)
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    byteswap_job_scheduler_if.slave        bus,
    output logic                           busy,
    output logic                           stalled
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CPL,
        S_HALT
    } state_e;

    state_e                       state_q, state_d;
    logic [LP_ID_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
    logic                         ctrl_start_q, ctrl_start_d;
    logic [C_ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [C_XFER_SIZE_WIDTH-1:0] bytes_q, bytes_d;
    logic                         cpl_valid_q, cpl_valid_d;
    logic [LP_ID_WIDTH-1:0]       cpl_id_q, cpl_id_d;
    logic                         rd_seen_q, rd_seen_d;
    logic                         wr_seen_q, wr_seen_d;
    logic                         busy_q, busy_d;
    logic                         timed_out;

`ifdef BYTESWAP_SCHED_TIMEOUT_EN
    localparam logic [31:0] LP_TIMEOUT_LAST = 32'(C_TIMEOUT_CYCLES - 1);

    logic        cpl_status_q, cpl_status_d;
    logic        stalled_q, stalled_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;

    assign timed_out = cpl_status_q;
`else
    assign timed_out = 1'b0;
`endif

    logic                         grant_found;
    logic [LP_ID_WIDTH-1:0]       grant_id;
    logic [C_ADDR_WIDTH-1:0]      grant_addr;
    logic [C_XFER_SIZE_WIDTH-1:0] grant_bytes;
    logic                         accept;
    logic                         rd_now, wr_now;

    // First requester at or after rr_ptr, wrapping; no power-of-two assumption on C_NUM_REQ.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < C_NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % C_NUM_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = LP_ID_WIDTH'(idx);
            end
        end
    end

    assign accept      = (state_q == S_IDLE) && grant_found;
    assign grant_addr  = bus.req_addr[int'(grant_id)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
    assign grant_bytes = bus.req_bytes[int'(grant_id)*C_XFER_SIZE_WIDTH +: C_XFER_SIZE_WIDTH];
    assign rd_now      = rd_seen_q | bus.rd_done;
    assign wr_now      = wr_seen_q | bus.wr_done;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        ctrl_start_d = 1'b0;
        addr_d       = addr_q;
        bytes_d      = bytes_q;
        cpl_valid_d  = cpl_valid_q;
        cpl_id_d     = cpl_id_q;
        rd_seen_d    = rd_seen_q;
        wr_seen_d    = wr_seen_q;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
        cpl_status_d = cpl_status_q;
        stalled_d    = stalled_q;
        wd_cnt_d     = wd_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d   = grant_addr;
                    bytes_d  = grant_bytes;
                    cpl_id_d = grant_id;
                    rr_ptr_d = LP_ID_WIDTH'((int'(grant_id) + 1) % C_NUM_REQ);
                    if (grant_bytes == '0) begin
                        state_d     = S_CPL;
                        cpl_valid_d = 1'b1;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
                        cpl_status_d = 1'b0;
`endif
                    end else begin
                        state_d      = S_LAUNCH;
                        ctrl_start_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                rd_seen_d = 1'b0;
                wr_seen_d = 1'b0;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
                wd_cnt_d  = '0;
`endif
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                rd_seen_d = rd_now;
                wr_seen_d = wr_now;
                if (rd_now && wr_now) begin
                    state_d     = S_CPL;
                    cpl_valid_d = 1'b1;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
                    cpl_status_d = 1'b0;
                end else if (wd_cnt_q == LP_TIMEOUT_LAST) begin
                    state_d      = S_CPL;
                    cpl_valid_d  = 1'b1;
                    cpl_status_d = 1'b1;
                    stalled_d    = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
`endif
                end
            end
            S_CPL: begin
                if (bus.cpl_ready) begin
                    cpl_valid_d = 1'b0;
                    state_d     = timed_out ? S_HALT : S_IDLE;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            ctrl_start_q <= 1'b0;
            addr_q       <= '0;
            bytes_q      <= '0;
            cpl_valid_q  <= 1'b0;
            cpl_id_q     <= '0;
            rd_seen_q    <= 1'b0;
            wr_seen_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
            cpl_status_q <= 1'b0;
            stalled_q    <= 1'b0;
            wd_cnt_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            ctrl_start_q <= ctrl_start_d;
            addr_q       <= addr_d;
            bytes_q      <= bytes_d;
            cpl_valid_q  <= cpl_valid_d;
            cpl_id_q     <= cpl_id_d;
            rd_seen_q    <= rd_seen_d;
            wr_seen_q    <= wr_seen_d;
            busy_q       <= busy_d;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
            cpl_status_q <= cpl_status_d;
            stalled_q    <= stalled_d;
            wd_cnt_q     <= wd_cnt_d;
`endif
        end
    end

    assign bus.ctrl_start       = ctrl_start_q;
    assign bus.ctrl_addr_offset = addr_q;
    assign bus.ctrl_xfer_bytes  = bytes_q;
    assign bus.cpl_valid        = cpl_valid_q;
    assign bus.cpl_id           = cpl_id_q;
    assign busy                 = busy_q;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
    assign bus.cpl_status = cpl_status_q;
    assign stalled        = stalled_q;
`else
    assign bus.cpl_status = 1'b0;
    assign stalled        = 1'b0;
`endif

endmodule
